// File: rtl/rename_map_multi_if.sv
// Rename stage bundle: issue group in, registered rename results out, retire port and
// free-list status.
//   master: decode/ROB side (drives issue_*, rd/rs*, retire_*)
//   slave : the renamer (drives issue_ready, out_valid, phys_*, free-list status)
// Optional checkpoint signals (ckpt_save, flush, ckpt_valid) exist only when
// RENAME_CHECKPOINT_EN is defined.
interface rename_map_multi_if #(
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned ISSUE_WIDTH = 2
);
    localparam int unsigned AREG_W = $clog2(ARCH_REGS);
    localparam int unsigned PREG_W = $clog2(PHYS_REGS);

    logic [ISSUE_WIDTH-1:0]        issue_valid;
    logic [ISSUE_WIDTH-1:0]        rd_write;
    logic [ISSUE_WIDTH*AREG_W-1:0] rd;
    logic [ISSUE_WIDTH*AREG_W-1:0] rs1;
    logic [ISSUE_WIDTH*AREG_W-1:0] rs2;
    logic                          issue_ready;
    logic [ISSUE_WIDTH-1:0]        out_valid;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rd;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rs1;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rs2;
    logic [ISSUE_WIDTH*PREG_W-1:0] old_phys_rd;
    logic                          retire_valid;
    logic [PREG_W-1:0]             retire_phys_reg;
    logic [PREG_W:0]               free_count;
    logic                          free_list_empty;
    logic                          err_overflow;
`ifdef RENAME_CHECKPOINT_EN
    logic                          ckpt_save;
    logic                          flush;
    logic                          ckpt_valid;
`endif

    modport master (
        output issue_valid, rd_write, rd, rs1, rs2, retire_valid, retire_phys_reg,
        input  issue_ready, out_valid, phys_rd, phys_rs1, phys_rs2, old_phys_rd,
        input  free_count, free_list_empty, err_overflow
`ifdef RENAME_CHECKPOINT_EN
        , output ckpt_save, flush
        , input  ckpt_valid
`endif
    );

    modport slave (
        input  issue_valid, rd_write, rd, rs1, rs2, retire_valid, retire_phys_reg,
        output issue_ready, out_valid, phys_rd, phys_rs1, phys_rs2, old_phys_rd,
        output free_count, free_list_empty, err_overflow
`ifdef RENAME_CHECKPOINT_EN
        , input  ckpt_save, flush
        , output ckpt_valid
`endif
    );
endinterface

// File: rtl/rename_map_multi.sv
// Multi-lane register rename stage. Maps ISSUE_WIDTH instructions per cycle from
// architectural to physical registers using a RAT and a circular free list, and
// reports the previous mapping of each rd (old_phys_rd) for the ROB.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - rename_map_multi_if.slave: issue group, registered results, retire port,
//           free-list status, sticky err_overflow
// Optional feature: define RENAME_CHECKPOINT_EN for a single RAT/free-list checkpoint
// with ckpt_save / flush / ckpt_valid on the interface.
module rename_map_multi #(
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned ISSUE_WIDTH = 2
) (
    input  logic clk,
    input  logic reset,
    rename_map_multi_if.slave bus
);
    localparam int unsigned AREG_W   = $clog2(ARCH_REGS);
    localparam int unsigned PREG_W   = $clog2(PHYS_REGS);
    localparam int unsigned CNT_W    = PREG_W + 1;
    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FL_IW    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    // Inputs never exceed 2*FL_DEPTH-1, so one conditional subtract wraps the pointer.
    function automatic logic [FL_IW-1:0] fl_wrap(input int v);
        int r;
        r = (v >= int'(FL_DEPTH)) ? v - int'(FL_DEPTH) : v;
        return FL_IW'(r);
    endfunction

    logic [PREG_W-1:0] rat_q [ARCH_REGS];
    logic [PREG_W-1:0] rat_d [ARCH_REGS];
    logic [PREG_W-1:0] fl_q  [FL_DEPTH];
    logic [PREG_W-1:0] fl_d  [FL_DEPTH];
    logic [FL_IW-1:0]  head_q, head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic [ISSUE_WIDTH-1:0]        out_valid_q, out_valid_d;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rd_q, phys_rd_d;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rs1_q, phys_rs1_d;
    logic [ISSUE_WIDTH*PREG_W-1:0] phys_rs2_q, phys_rs2_d;
    logic [ISSUE_WIDTH*PREG_W-1:0] old_rd_q, old_rd_d;

    logic [AREG_W-1:0] rd_a   [ISSUE_WIDTH];
    logic [AREG_W-1:0] rs1_a  [ISSUE_WIDTH];
    logic [AREG_W-1:0] rs2_a  [ISSUE_WIDTH];
    logic [PREG_W-1:0] new_p  [ISSUE_WIDTH];
    logic [PREG_W-1:0] src1   [ISSUE_WIDTH];
    logic [PREG_W-1:0] src2   [ISSUE_WIDTH];
    logic [PREG_W-1:0] old_p  [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] alloc;
    logic              issue_ready;
    logic              fire;
    logic              retire_acc;
    int                n_alloc;

`ifdef RENAME_CHECKPOINT_EN
    logic [PREG_W-1:0] ckpt_rat_q [ARCH_REGS];
    logic [PREG_W-1:0] ckpt_rat_d [ARCH_REGS];
    logic [FL_IW-1:0]  ckpt_head_q, ckpt_head_d;
    logic [CNT_W-1:0]  ckpt_count_q, ckpt_count_d;
    logic              ckpt_valid_q, ckpt_valid_d;
    logic              flush_act;
`endif

    // Registered count only, so ready never depends on issue_valid.
    assign issue_ready = count_q >= CNT_W'(ISSUE_WIDTH);

    always_comb begin
        rat_d       = rat_q;
        fl_d        = fl_q;
        head_d      = head_q;
        count_d     = count_q;
        err_d       = err_q;
        out_valid_d = '0;
        phys_rd_d   = phys_rd_q;
        phys_rs1_d  = phys_rs1_q;
        phys_rs2_d  = phys_rs2_q;
        old_rd_d    = old_rd_q;
        n_alloc     = 0;

        retire_acc = bus.retire_valid && (count_q != CNT_W'(FL_DEPTH))
                     && (bus.retire_phys_reg != '0);
        if (bus.retire_valid && !retire_acc) begin
            err_d = 1'b1;
        end

        fire = (|bus.issue_valid) && issue_ready;
`ifdef RENAME_CHECKPOINT_EN
        flush_act = bus.flush && ckpt_valid_q;
        if (flush_act) begin
            fire = 1'b0;
        end
`endif

        // Allocations take consecutive free-list entries in lane order.
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            rd_a[k]  = bus.rd[k*AREG_W +: AREG_W];
            rs1_a[k] = bus.rs1[k*AREG_W +: AREG_W];
            rs2_a[k] = bus.rs2[k*AREG_W +: AREG_W];
            alloc[k] = bus.issue_valid[k] && bus.rd_write[k] && (rd_a[k] != '0);
            new_p[k] = '0;
            if (alloc[k]) begin
                new_p[k] = fl_q[fl_wrap(int'(head_q) + n_alloc)];
                n_alloc  = n_alloc + 1;
            end
        end

        // RAT[0] is never written, so x0 sources read 0. Older lanes in the group
        // override the RAT; the later (newer) matching lane wins.
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            src1[k]  = rat_q[rs1_a[k]];
            src2[k]  = rat_q[rs2_a[k]];
            old_p[k] = alloc[k] ? rat_q[rd_a[k]] : '0;
            for (int j = 0; j < k; j++) begin
                if (alloc[j] && rd_a[j] == rs1_a[k]) src1[k] = new_p[j];
                if (alloc[j] && rd_a[j] == rs2_a[k]) src2[k] = new_p[j];
                if (alloc[j] && alloc[k] && rd_a[j] == rd_a[k]) old_p[k] = new_p[j];
            end
        end

        if (fire) begin
            out_valid_d = bus.issue_valid;
            head_d      = fl_wrap(int'(head_q) + n_alloc);
            count_d     = count_q - CNT_W'(n_alloc);
            for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
                phys_rd_d[k*PREG_W +: PREG_W]  = new_p[k];
                phys_rs1_d[k*PREG_W +: PREG_W] = src1[k];
                phys_rs2_d[k*PREG_W +: PREG_W] = src2[k];
                old_rd_d[k*PREG_W +: PREG_W]   = old_p[k];
                // Youngest lane writing the same rd lands last.
                if (alloc[k]) rat_d[rd_a[k]] = new_p[k];
            end
        end

        // Tail is head+count; the pushed slot is never one being allocated now.
        if (retire_acc) begin
            fl_d[fl_wrap(int'(head_q) + int'(count_q))] = bus.retire_phys_reg;
            count_d = count_d + 1'b1;
        end

`ifdef RENAME_CHECKPOINT_EN
        ckpt_rat_d   = ckpt_rat_q;
        ckpt_head_d  = ckpt_head_q;
        ckpt_count_d = ckpt_count_q;
        ckpt_valid_d = ckpt_valid_q;
        if (fire && bus.ckpt_save) begin
            ckpt_rat_d   = rat_d;
            ckpt_head_d  = head_d;
            ckpt_count_d = count_d;
            ckpt_valid_d = 1'b1;
        end else if (ckpt_valid_q && retire_acc) begin
            ckpt_count_d = ckpt_count_q + 1'b1;
        end
        // Entries retired since the snapshot sit right behind the restored
        // head+count, so the free-list storage itself needs no restore.
        if (flush_act) begin
            rat_d        = ckpt_rat_q;
            head_d       = ckpt_head_q;
            count_d      = ckpt_count_q + CNT_W'(retire_acc);
            ckpt_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) rat_q[i] <= PREG_W'(i);
            for (int i = 0; i < int'(FL_DEPTH); i++) fl_q[i] <= PREG_W'(ARCH_REGS + i);
            head_q      <= '0;
            count_q     <= CNT_W'(FL_DEPTH);
            err_q       <= 1'b0;
            out_valid_q <= '0;
            phys_rd_q   <= '0;
            phys_rs1_q  <= '0;
            phys_rs2_q  <= '0;
            old_rd_q    <= '0;
        end else begin
            rat_q       <= rat_d;
            fl_q        <= fl_d;
            head_q      <= head_d;
            count_q     <= count_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            phys_rd_q   <= phys_rd_d;
            phys_rs1_q  <= phys_rs1_d;
            phys_rs2_q  <= phys_rs2_d;
            old_rd_q    <= old_rd_d;
        end
    end

`ifdef RENAME_CHECKPOINT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) ckpt_rat_q[i] <= PREG_W'(i);
            ckpt_head_q  <= '0;
            ckpt_count_q <= CNT_W'(FL_DEPTH);
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_rat_q   <= ckpt_rat_d;
            ckpt_head_q  <= ckpt_head_d;
            ckpt_count_q <= ckpt_count_d;
            ckpt_valid_q <= ckpt_valid_d;
        end
    end

    assign bus.ckpt_valid = ckpt_valid_q;
`endif

    assign bus.issue_ready     = issue_ready;
    assign bus.out_valid       = out_valid_q;
    assign bus.phys_rd         = phys_rd_q;
    assign bus.phys_rs1        = phys_rs1_q;
    assign bus.phys_rs2        = phys_rs2_q;
    assign bus.old_phys_rd     = old_rd_q;
    assign bus.free_count      = count_q;
    assign bus.free_list_empty = (count_q == '0);
    assign bus.err_overflow    = err_q;
endmodule

// File: tb/tb_rename_map_multi.sv
module tb_rename_map_multi;
    localparam int unsigned AR = 32;
    localparam int unsigned PR = 64;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rename_map_multi_if #(.ARCH_REGS(AR), .PHYS_REGS(PR), .ISSUE_WIDTH(IW)) bus ();

    rename_map_multi #(.ARCH_REGS(AR), .PHYS_REGS(PR), .ISSUE_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] lane(input logic [11:0] v, input int k);
        return v[k*6 +: 6];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid     = '0;
        bus.rd_write        = '0;
        bus.rd              = '0;
        bus.rs1             = '0;
        bus.rs2             = '0;
        bus.retire_valid    = 1'b0;
        bus.retire_phys_reg = '0;
`ifdef RENAME_CHECKPOINT_EN
        bus.ckpt_save       = 1'b0;
        bus.flush           = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Lane k fields: valid, write, rd, rs1, rs2.
    task automatic set_lane(input int k, input logic v, input logic w,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        bus.issue_valid[k]     = v;
        bus.rd_write[k]        = w;
        bus.rd[k*5 +: 5]       = d;
        bus.rs1[k*5 +: 5]      = s1;
        bus.rs2[k*5 +: 5]      = s2;
    endtask

    task automatic retire(input logic [5:0] r);
        bus.retire_valid    = 1'b1;
        bus.retire_phys_reg = r;
    endtask

    initial begin
        idle();
        #1;
        tick();
        do_reset();

        // Reset state
        check_eq("rst_count", bus.free_count, 32);
        check_eq("rst_empty", bus.free_list_empty, 0);
        check_eq("rst_ready", bus.issue_ready, 1);
        check_eq("rst_oval", bus.out_valid, 0);
        check_eq("rst_prd", bus.phys_rd, 0);
        check_eq("rst_err", bus.err_overflow, 0);

        // 1: basic two-lane rename with rs1 bypass
        set_lane(0, 1, 1, 1, 2, 3);
        set_lane(1, 1, 1, 2, 1, 2);
        tick();
        idle();
        check_eq("t1_oval", bus.out_valid, 3);
        check_eq("t1_l0_rd", lane(bus.phys_rd, 0), 32);
        check_eq("t1_l0_rs1", lane(bus.phys_rs1, 0), 2);
        check_eq("t1_l0_rs2", lane(bus.phys_rs2, 0), 3);
        check_eq("t1_l0_old", lane(bus.old_phys_rd, 0), 1);
        check_eq("t1_l1_rd", lane(bus.phys_rd, 1), 33);
        check_eq("t1_l1_rs1", lane(bus.phys_rs1, 1), 32);
        check_eq("t1_l1_rs2", lane(bus.phys_rs2, 1), 2);
        check_eq("t1_l1_old", lane(bus.old_phys_rd, 1), 2);
        check_eq("t1_count", bus.free_count, 30);
        tick();
        check_eq("t1_idle_oval", bus.out_valid, 0);
        check_eq("t1_hold_rd", lane(bus.phys_rd, 1), 33);

        // 2: same rd in both lanes, then x0 / invalid lane
        do_reset();
        set_lane(0, 1, 1, 5, 0, 0);
        set_lane(1, 1, 1, 5, 0, 0);
        tick();
        idle();
        check_eq("t2_l0_rd", lane(bus.phys_rd, 0), 32);
        check_eq("t2_l0_old", lane(bus.old_phys_rd, 0), 5);
        check_eq("t2_l1_rd", lane(bus.phys_rd, 1), 33);
        check_eq("t2_l1_old", lane(bus.old_phys_rd, 1), 32);
        set_lane(0, 1, 1, 0, 5, 0);
        set_lane(1, 0, 1, 7, 0, 0);
        tick();
        idle();
        check_eq("t2_x0_oval", bus.out_valid, 1);
        check_eq("t2_x0_rd", lane(bus.phys_rd, 0), 0);
        check_eq("t2_x0_old", lane(bus.old_phys_rd, 0), 0);
        check_eq("t2_rat5", lane(bus.phys_rs1, 0), 33);
        check_eq("t2_rs2_x0", lane(bus.phys_rs2, 0), 0);
        check_eq("t2_count", bus.free_count, 30);

        // 3: drain the free list
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_lane(0, 1, 1, 6, 0, 0);
            set_lane(1, 1, 1, 7, 0, 0);
            tick();
        end
        idle();
        check_eq("t3_count", bus.free_count, 0);
        check_eq("t3_empty", bus.free_list_empty, 1);
        check_eq("t3_ready", bus.issue_ready, 0);
        set_lane(0, 1, 1, 6, 0, 0);
        set_lane(1, 1, 1, 7, 0, 0);
        tick();
        idle();
        check_eq("t3_blk_oval", bus.out_valid, 0);
        check_eq("t3_blk_count", bus.free_count, 0);

        // 4: refill to 2, concurrent retire+alloc, wrap order
        retire(11);
        tick();
        retire(12);
        tick();
        idle();
        check_eq("t4_count2", bus.free_count, 2);
        check_eq("t4_ready2", bus.issue_ready, 1);
        set_lane(0, 1, 1, 6, 0, 0);
        set_lane(1, 1, 1, 7, 0, 0);
        retire(7);
        tick();
        idle();
        check_eq("t4_l0_rd", lane(bus.phys_rd, 0), 11);
        check_eq("t4_l1_rd", lane(bus.phys_rd, 1), 12);
        check_eq("t4_count1", bus.free_count, 1);
        check_eq("t4_ready1", bus.issue_ready, 0);
        retire(9);
        tick();
        idle();
        check_eq("t4_count_r9", bus.free_count, 2);
        check_eq("t4_ready_r9", bus.issue_ready, 1);
        set_lane(0, 1, 1, 6, 0, 0);
        set_lane(1, 1, 1, 7, 0, 0);
        tick();
        idle();
        check_eq("t4_wrap_l0", lane(bus.phys_rd, 0), 7);
        check_eq("t4_wrap_l1", lane(bus.phys_rd, 1), 9);
        check_eq("t4_wrap_count", bus.free_count, 0);

        // 5: illegal retires
        retire(0);
        tick();
        idle();
        check_eq("t5_p0_err", bus.err_overflow, 1);
        check_eq("t5_p0_count", bus.free_count, 0);
        do_reset();
        check_eq("t5_rst_err", bus.err_overflow, 0);
        retire(40);
        tick();
        idle();
        check_eq("t5_full_count", bus.free_count, 32);
        check_eq("t5_full_err", bus.err_overflow, 1);
        tick();
        check_eq("t5_sticky", bus.err_overflow, 1);

`ifdef RENAME_CHECKPOINT_EN
        // 6: checkpoint save, speculate, retire, flush
        do_reset();
        check_eq("t6_rst_cv", bus.ckpt_valid, 0);
        set_lane(0, 1, 1, 4, 0, 0);
        bus.ckpt_save = 1'b1;
        tick();
        idle();
        check_eq("t6_save_rd", lane(bus.phys_rd, 0), 32);
        check_eq("t6_cv", bus.ckpt_valid, 1);
        set_lane(0, 1, 1, 4, 0, 0);
        tick();
        idle();
        check_eq("t6_spec_rd", lane(bus.phys_rd, 0), 33);
        retire(20);
        tick();
        idle();
        check_eq("t6_count_pre", bus.free_count, 31);
        bus.flush = 1'b1;
        set_lane(0, 1, 1, 8, 0, 0);
        tick();
        idle();
        check_eq("t6_fl_oval", bus.out_valid, 0);
        check_eq("t6_fl_count", bus.free_count, 32);
        check_eq("t6_fl_cv", bus.ckpt_valid, 0);
        set_lane(0, 1, 1, 4, 4, 0);
        bus.ckpt_save = 1'b1;
        tick();
        idle();
        check_eq("t6_next_rd", lane(bus.phys_rd, 0), 33);
        check_eq("t6_rat4", lane(bus.phys_rs1, 0), 32);
        check_eq("t6_old4", lane(bus.old_phys_rd, 0), 32);
        check_eq("t6_cv2", bus.ckpt_valid, 1);
        do_reset();
        check_eq("t6_rst_cv2", bus.ckpt_valid, 0);
        check_eq("t6_rst_count", bus.free_count, 32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
